// File: rtl/sc_statemachineplayer_if.sv
// Frog player controller bus: active-low buttons in, register strobes,
// position, lives and game status out. master = stimulus side, slave = controller.
interface sc_statemachineplayer_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic                      SC_STATEMACHINEPLAYER_startButton_InLow;
    logic                      SC_STATEMACHINEPLAYER_upButton_InLow;
    logic                      SC_STATEMACHINEPLAYER_downButton_InLow;
    logic                      SC_STATEMACHINEPLAYER_leftButton_InLow;
    logic                      SC_STATEMACHINEPLAYER_rightButton_InLow;
    logic                      SC_STATEMACHINEPLAYER_Losing_InLow;
    logic                      SC_STATEMACHINEPLAYER_clear_OutLow;
    logic                      SC_STATEMACHINEPLAYER_loadUp_OutLow;
    logic                      SC_STATEMACHINEPLAYER_loadDown_OutLow;
    logic [1:0]                SC_STATEMACHINEPLAYER_shiftselection_Out;
    logic [$clog2(ROWS)-1:0]   SC_STATEMACHINEPLAYER_row_Out;
    logic [$clog2(COLS)-1:0]   SC_STATEMACHINEPLAYER_col_Out;
    logic [3:0]                SC_STATEMACHINEPLAYER_lives_Out;
    logic                      SC_STATEMACHINEPLAYER_win_OutHigh;
    logic                      SC_STATEMACHINEPLAYER_gameOver_OutHigh;

    modport master (
        output SC_STATEMACHINEPLAYER_startButton_InLow,
        output SC_STATEMACHINEPLAYER_upButton_InLow,
        output SC_STATEMACHINEPLAYER_downButton_InLow,
        output SC_STATEMACHINEPLAYER_leftButton_InLow,
        output SC_STATEMACHINEPLAYER_rightButton_InLow,
        output SC_STATEMACHINEPLAYER_Losing_InLow,
        input  SC_STATEMACHINEPLAYER_clear_OutLow,
        input  SC_STATEMACHINEPLAYER_loadUp_OutLow,
        input  SC_STATEMACHINEPLAYER_loadDown_OutLow,
        input  SC_STATEMACHINEPLAYER_shiftselection_Out,
        input  SC_STATEMACHINEPLAYER_row_Out,
        input  SC_STATEMACHINEPLAYER_col_Out,
        input  SC_STATEMACHINEPLAYER_lives_Out,
        input  SC_STATEMACHINEPLAYER_win_OutHigh,
        input  SC_STATEMACHINEPLAYER_gameOver_OutHigh
    );

    modport slave (
        input  SC_STATEMACHINEPLAYER_startButton_InLow,
        input  SC_STATEMACHINEPLAYER_upButton_InLow,
        input  SC_STATEMACHINEPLAYER_downButton_InLow,
        input  SC_STATEMACHINEPLAYER_leftButton_InLow,
        input  SC_STATEMACHINEPLAYER_rightButton_InLow,
        input  SC_STATEMACHINEPLAYER_Losing_InLow,
        output SC_STATEMACHINEPLAYER_clear_OutLow,
        output SC_STATEMACHINEPLAYER_loadUp_OutLow,
        output SC_STATEMACHINEPLAYER_loadDown_OutLow,
        output SC_STATEMACHINEPLAYER_shiftselection_Out,
        output SC_STATEMACHINEPLAYER_row_Out,
        output SC_STATEMACHINEPLAYER_col_Out,
        output SC_STATEMACHINEPLAYER_lives_Out,
        output SC_STATEMACHINEPLAYER_win_OutHigh,
        output SC_STATEMACHINEPLAYER_gameOver_OutHigh
    );
endinterface

// File: rtl/sc_statemachineplayer.sv
// Frog player controller: turns active-low buttons into one-cycle register
// strobes, tracks row/col with edge blocking, lives, win and game over.
// Ports: SC_STATEMACHINEPLAYER_CLOCK_50, SC_STATEMACHINEPLAYER_RESET_InLow
// (async, active low), bus (sc_statemachineplayer_if.slave: buttons,
// Losing in; clear/loadUp/loadDown/shiftselection strobes, row, col,
// lives, win, gameOver out).
// Optional hold-repeat: define SC_STATEMACHINEPLAYER_AUTOREPEAT_EN.
module sc_statemachineplayer #(
    parameter int ROWS          = 8,
    parameter int COLS          = 8,
    parameter int LIVES         = 3,
    parameter int REPEAT_CYCLES = 12_500_000
) (
    input  logic                         SC_STATEMACHINEPLAYER_CLOCK_50,
    input  logic                         SC_STATEMACHINEPLAYER_RESET_InLow,
    sc_statemachineplayer_if.slave       bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [CW-1:0] COL_MID  = CW'(COLS / 2);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_PRE  = RW'(ROWS - 2);
    localparam logic [3:0]    LIVES_I  = 4'(LIVES);

    if (ROWS < 3) begin : g_bad_rows
        $error("sc_statemachineplayer: ROWS must be >= 3");
    end
    if (COLS < 2) begin : g_bad_cols
        $error("sc_statemachineplayer: COLS must be >= 2");
    end
    if (LIVES < 1 || LIVES > 15) begin : g_bad_lives
        $error("sc_statemachineplayer: LIVES must be 1..15");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_rpt
        $error("sc_statemachineplayer: REPEAT_CYCLES must be >= 1");
    end

    typedef enum logic [3:0] {
        S_RESET, S_IDLE, S_INIT, S_CHECK, S_UP, S_DOWN,
        S_LEFT, S_RIGHT, S_HOLD, S_HIT, S_WIN, S_GAMEOVER
    } state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [3:0]    lives_q, lives_d;

    logic start_n, up_n, down_n, left_n, right_n, lose_n;
    logic any_move, any_btn;

    assign start_n  = bus.SC_STATEMACHINEPLAYER_startButton_InLow;
    assign up_n     = bus.SC_STATEMACHINEPLAYER_upButton_InLow;
    assign down_n   = bus.SC_STATEMACHINEPLAYER_downButton_InLow;
    assign left_n   = bus.SC_STATEMACHINEPLAYER_leftButton_InLow;
    assign right_n  = bus.SC_STATEMACHINEPLAYER_rightButton_InLow;
    assign lose_n   = bus.SC_STATEMACHINEPLAYER_Losing_InLow;
    assign any_move = !(up_n && down_n && left_n && right_n);
    assign any_btn  = any_move || !start_n;

`ifdef SC_STATEMACHINEPLAYER_AUTOREPEAT_EN
    localparam int RCW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RCW-1:0] RPT_LAST = RCW'(REPEAT_CYCLES - 1);
    logic [RCW-1:0] rpt_q, rpt_d;
    logic           rpt_fire;

    // Zero outside HOLD, so every HOLD entry starts a fresh interval.
    always_comb begin
        rpt_d = '0;
        if (state_q == S_HOLD && any_move) rpt_d = rpt_q + 1'b1;
    end
    assign rpt_fire = any_move && (rpt_q == RPT_LAST);

    always_ff @(posedge SC_STATEMACHINEPLAYER_CLOCK_50 or
                negedge SC_STATEMACHINEPLAYER_RESET_InLow) begin
        if (!SC_STATEMACHINEPLAYER_RESET_InLow) rpt_q <= '0;
        else                                    rpt_q <= rpt_d;
    end
`else
    logic rpt_fire;
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge SC_STATEMACHINEPLAYER_CLOCK_50 or
                negedge SC_STATEMACHINEPLAYER_RESET_InLow) begin
        if (!SC_STATEMACHINEPLAYER_RESET_InLow) begin
            state_q <= S_RESET;
            row_q   <= '0;
            col_q   <= COL_MID;
            lives_q <= LIVES_I;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            lives_q <= lives_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        lives_d = lives_q;
        unique case (state_q)
            S_RESET: state_d = S_IDLE;
            S_IDLE:  if (!start_n) state_d = S_INIT;
            S_INIT: begin
                row_d   = '0;
                col_d   = COL_MID;
                state_d = S_HOLD;
            end
            S_CHECK: begin
                // Blocked moves fall through and stay in CHECK.
                if (!lose_n)                          state_d = S_HIT;
                else if (!start_n)                    state_d = S_INIT;
                else if (!up_n)                       state_d = S_UP;
                else if (!down_n)  begin
                    if (row_q != '0)                  state_d = S_DOWN;
                end else if (!left_n) begin
                    if (col_q != '0)                  state_d = S_LEFT;
                end else if (!right_n) begin
                    if (col_q != COL_LAST)            state_d = S_RIGHT;
                end
            end
            S_UP: begin
                row_d   = row_q + 1'b1;
                state_d = (row_q == ROW_PRE) ? S_WIN : S_HOLD;
            end
            S_DOWN: begin
                row_d   = row_q - 1'b1;
                state_d = S_HOLD;
            end
            S_LEFT: begin
                col_d   = col_q - 1'b1;
                state_d = S_HOLD;
            end
            S_RIGHT: begin
                col_d   = col_q + 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!lose_n)       state_d = S_HIT;
                else if (rpt_fire) state_d = S_CHECK;
                else if (!any_btn) state_d = S_CHECK;
            end
            S_HIT: begin
                if (lives_q != 4'd0) lives_d = lives_q - 4'd1;
                state_d = (lives_q <= 4'd1) ? S_GAMEOVER : S_INIT;
            end
            S_WIN: state_d = S_INIT;
            S_GAMEOVER: begin
                if (!start_n) begin
                    lives_d = LIVES_I;
                    state_d = S_INIT;
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    always_comb begin
        bus.SC_STATEMACHINEPLAYER_clear_OutLow       = 1'b1;
        bus.SC_STATEMACHINEPLAYER_loadUp_OutLow      = 1'b1;
        bus.SC_STATEMACHINEPLAYER_loadDown_OutLow    = 1'b1;
        bus.SC_STATEMACHINEPLAYER_shiftselection_Out = 2'b11;
        bus.SC_STATEMACHINEPLAYER_win_OutHigh        = 1'b0;
        bus.SC_STATEMACHINEPLAYER_gameOver_OutHigh   = 1'b0;
        unique case (state_q)
            S_RESET, S_INIT: bus.SC_STATEMACHINEPLAYER_clear_OutLow = 1'b0;
            S_UP:    bus.SC_STATEMACHINEPLAYER_loadUp_OutLow   = 1'b0;
            S_DOWN:  bus.SC_STATEMACHINEPLAYER_loadDown_OutLow = 1'b0;
            S_LEFT:  bus.SC_STATEMACHINEPLAYER_shiftselection_Out = 2'b01;
            S_RIGHT: bus.SC_STATEMACHINEPLAYER_shiftselection_Out = 2'b10;
            S_WIN: begin
                bus.SC_STATEMACHINEPLAYER_win_OutHigh  = 1'b1;
                bus.SC_STATEMACHINEPLAYER_clear_OutLow = 1'b0;
            end
            S_GAMEOVER: bus.SC_STATEMACHINEPLAYER_gameOver_OutHigh = 1'b1;
            default: ;
        endcase
    end

    assign bus.SC_STATEMACHINEPLAYER_row_Out   = row_q;
    assign bus.SC_STATEMACHINEPLAYER_col_Out   = col_q;
    assign bus.SC_STATEMACHINEPLAYER_lives_Out = lives_q;
endmodule

// File: tb/tb_sc_statemachineplayer.sv
// Directed bench for sc_statemachineplayer: strobe scoreboard plus
// immediate-assertion checks on position, lives and status.
module tb_sc_statemachineplayer;
    localparam int R = 20;
    localparam int HOLD_LEN = 3 * R + 8;
`ifdef SC_STATEMACHINEPLAYER_AUTOREPEAT_EN
    localparam int HOLD_UPS = 4;
`else
    localparam int HOLD_UPS = 1;
`endif
    localparam int EV_UP = 1, EV_DN = 2, EV_LT = 3, EV_RT = 4, EV_WIN = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_n = 1'b1, up_n = 1'b1, down_n = 1'b1;
    logic left_n = 1'b1, right_n = 1'b1, lose_n = 1'b1;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int up_cnt = 0;
    int win_cnt = 0;

    always #5 clk = ~clk;

    sc_statemachineplayer_if #(.ROWS(8), .COLS(8)) bus ();

    assign bus.SC_STATEMACHINEPLAYER_startButton_InLow = start_n;
    assign bus.SC_STATEMACHINEPLAYER_upButton_InLow    = up_n;
    assign bus.SC_STATEMACHINEPLAYER_downButton_InLow  = down_n;
    assign bus.SC_STATEMACHINEPLAYER_leftButton_InLow  = left_n;
    assign bus.SC_STATEMACHINEPLAYER_rightButton_InLow = right_n;
    assign bus.SC_STATEMACHINEPLAYER_Losing_InLow      = lose_n;

    wire       clr_n = bus.SC_STATEMACHINEPLAYER_clear_OutLow;
    wire       ldu_n = bus.SC_STATEMACHINEPLAYER_loadUp_OutLow;
    wire       ldd_n = bus.SC_STATEMACHINEPLAYER_loadDown_OutLow;
    wire [1:0] shf   = bus.SC_STATEMACHINEPLAYER_shiftselection_Out;
    wire [2:0] row   = bus.SC_STATEMACHINEPLAYER_row_Out;
    wire [2:0] col   = bus.SC_STATEMACHINEPLAYER_col_Out;
    wire [3:0] lives = bus.SC_STATEMACHINEPLAYER_lives_Out;
    wire       win   = bus.SC_STATEMACHINEPLAYER_win_OutHigh;
    wire       gover = bus.SC_STATEMACHINEPLAYER_gameOver_OutHigh;

    sc_statemachineplayer #(
        .ROWS(8), .COLS(8), .LIVES(3), .REPEAT_CYCLES(R)
    ) dut (
        .SC_STATEMACHINEPLAYER_CLOCK_50  (clk),
        .SC_STATEMACHINEPLAYER_RESET_InLow(rst_n),
        .bus                              (bus.slave)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe cycle pops the next expected event.
    always @(negedge clk) begin
        int ev;
        ev = 0;
        if (rst_n) begin
            if (!ldu_n)          ev = EV_UP;
            else if (!ldd_n)     ev = EV_DN;
            else if (shf == 2'b01) ev = EV_LT;
            else if (shf == 2'b10) ev = EV_RT;
            else if (shf == 2'b00) ev = 9;
            else if (win)        ev = EV_WIN;
            if (ev == EV_UP)  up_cnt++;
            if (ev == EV_WIN) win_cnt++;
            if (ev != 0) begin
                if (exp_q.size() == 0) check("unexpected_strobe", ev, 0);
                else check("strobe", ev, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Press at CHECK, release after one clock, settle back to CHECK.
    task automatic press(input bit u, input bit d, input bit l, input bit r);
        up_n = !u; down_n = !d; left_n = !l; right_n = !r;
        tick();
        up_n = 1'b1; down_n = 1'b1; left_n = 1'b1; right_n = 1'b1;
        tick(4);
    endtask

    task automatic lose(input bit with_up);
        lose_n = 1'b0;
        up_n = !with_up;
        tick();
        lose_n = 1'b1;
        up_n = 1'b1;
        tick(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        check("rst_clear", clr_n, 0);
        check("rst_loadup", ldu_n, 1);
        check("rst_loaddn", ldd_n, 1);
        check("rst_shift", shf, 3);
        check("rst_row", row, 0);
        check("rst_col", col, 4);
        check("rst_lives", lives, 3);
        check("rst_win", win, 0);
        check("rst_gover", gover, 0);
        rst_n = 1'b1;
        tick();
        check("idle_clear", clr_n, 1);
        start_n = 1'b0;
        tick();
        check("init_clear", clr_n, 0);
        start_n = 1'b1;
        tick(3);

        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(EV_UP);
            press(1, 0, 0, 0);
        end
        check("row_after6", row, 6);
        exp_q.push_back(EV_UP);
        exp_q.push_back(EV_WIN);
        press(1, 0, 0, 0);
        check("up_pulses", up_cnt, 7);
        check("win_pulses", win_cnt, 1);
        check("row_after_win", row, 0);
        check("lives_after_win", lives, 3);

        press(0, 1, 0, 0);
        check("row0_down_block", row, 0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(EV_LT);
            press(0, 0, 1, 0);
        end
        check("col_left_edge", col, 0);
        press(0, 0, 1, 0);
        check("col0_left_block", col, 0);
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(EV_RT);
            press(0, 0, 0, 1);
        end
        check("col_right_edge", col, 7);
        press(0, 0, 0, 1);
        check("col7_right_block", col, 7);
        check("row_unchanged", row, 0);

        exp_q.push_back(EV_UP);
        press(1, 0, 1, 0);
        check("prio_row", row, 1);
        check("prio_col", col, 7);

        lose(1);
        check("hit1_lives", lives, 2);
        check("hit1_row", row, 0);
        check("hit1_col", col, 4);
        lose(0);
        check("hit2_lives", lives, 1);
        check("hit2_gover", gover, 0);
        lose(0);
        check("hit3_lives", lives, 0);
        check("hit3_gover", gover, 1);
        lose_n = 1'b0;
        tick(5);
        lose_n = 1'b1;
        check("gover_lose_ign", lives, 0);
        check("gover_stay", gover, 1);
        start_n = 1'b0;
        tick();
        check("restart_clear", clr_n, 0);
        check("restart_lives", lives, 3);
        check("restart_gover", gover, 0);
        start_n = 1'b1;
        tick(3);

        for (int i = 0; i < HOLD_UPS; i++) exp_q.push_back(EV_UP);
        up_cnt = 0;
        up_n = 1'b0;
        tick(HOLD_LEN);
        up_n = 1'b1;
        tick(4);
        check("hold_up_pulses", up_cnt, HOLD_UPS);
        check("hold_row", row, HOLD_UPS);

        exp_q.push_back(EV_LT);
        press(0, 0, 1, 0);
        check("pre_rst_col", col, 3);
        up_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midup_loadup", ldu_n, 1);
        check("midup_clear", clr_n, 0);
        check("midup_row", row, 0);
        check("midup_col", col, 4);
        check("midup_lives", lives, 3);
        check("midup_shift", shf, 3);
        up_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", clr_n, 1);
        start_n = 1'b0;
        tick();
        check("post_rst_init", clr_n, 0);
        start_n = 1'b1;
        tick();
        check("init_one_cycle", clr_n, 1);
        tick(2);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
